chaining_record_table: RTL and testbench

Scoreboard and read-port arbiter for vector-register chaining. It holds up to `NR_RECORDS` in-flight write records (destination group, instruction index, per-element-group written mask). Each cycle it checks every requester's pending VRF read against all live records. It then grants the single shared VRF read port, round-robin, to one hazard-free requester. It sits between the lane's operand-read requesters and the VRF read port, and replaces the per-record pass/fail checks instantiated at each requester.

---
 rtl/chaining_record_table.sv | 195 +++++++++++++++++++
 tb/tb_chaining_record_table.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chaining_record_table.sv
// ---------------------------------------------------------------------------
// chaining_record_table
//
// Chaining scoreboard plus round-robin arbiter for the single shared VRF read
// port. Each entry records an in-flight writer: destination group, its
// instruction index and which element groups it has written so far. Every
// cycle each pending reader is checked against all live entries. The read
// port is then granted to one hazard-free reader, round-robin.
//
// Handshake: read_ready is a combinational, one-hot-or-zero grant. A reader
// presenting read_valid is served in the cycle its read_ready bit is high.
// There is no back-pressure on the grant. alloc is taken when
// alloc_valid & alloc_ready, where alloc_ready reflects registered state only.
//
// Ports
//   clock, reset        rising-edge clock, async active-low reset
//   alloc_*             allocate a record (vd, vd_valid, instIndex)
//   write_*             OR an element-group mask into a live record
//   retire_*            free the live record with the given index
//   read_valid/vs/offset/instIndex  per-reader pending VRF read
//   read_ready          grant, one-hot-or-zero
//   record_count        number of live records
//   error               sticky: duplicate alloc or retire of absent index
// ---------------------------------------------------------------------------
module chaining_record_table #(
    parameter int NR_RECORDS = 4,
    parameter int NR_READERS = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic                      alloc_vd_valid,
    input  logic [4:0]                alloc_vd,
    input  logic [2:0]                alloc_instIndex,
    input  logic                      write_valid,
    input  logic [2:0]                write_instIndex,
    input  logic [15:0]               write_elementMask,
    input  logic                      retire_valid,
    input  logic [2:0]                retire_instIndex,
    input  logic [NR_READERS-1:0]     read_valid,
    input  logic [5*NR_READERS-1:0]   read_vs,
    input  logic [NR_READERS-1:0]     read_offset,
    input  logic [3*NR_READERS-1:0]   read_instIndex,
    output logic [NR_READERS-1:0]     read_ready,
    output logic [3:0]                record_count,
    output logic                      error
);

    localparam int EW = $clog2(NR_RECORDS);
    localparam int PW = (NR_READERS > 1) ? $clog2(NR_READERS) : 1;

    logic [NR_RECORDS-1:0] r_valid;
    logic [NR_RECORDS-1:0] r_vd_valid;
    logic [4:0]            r_vd   [NR_RECORDS];
    logic [2:0]            r_idx  [NR_RECORDS];
    logic [15:0]           r_mask [NR_RECORDS];
    logic [PW-1:0]         r_rr_ptr;
    logic                  r_error;

    logic                  w_alloc_ready;
    logic                  w_alloc_fire;
    logic                  w_dup;
    logic [EW-1:0]         w_free_idx;
    logic [NR_RECORDS-1:0] w_retire_hit;
    logic [NR_RECORDS-1:0] w_write_hit;
    logic [NR_READERS-1:0] w_elig;
    logic [NR_READERS-1:0] w_grant;
    logic                  w_found;
    logic [PW-1:0]         w_winner;
    logic [PW-1:0]         w_rr_next;
    logic [3:0]            w_count;

    // Wrap-around age compare on 3-bit instruction indices.
    function automatic logic older(input logic [2:0] r, input logic [2:0] e);
        return (r == e) || (((r[1:0] < e[1:0]) ^ r[2] ^ e[2]) != 1'b0);
    endfunction

    // True when this entry still owes the reader's element group.
    // A destination group spans 16 element groups starting at vd[2:0]*2 and
    // may spill into the next register bank; the position is (g - start)
    // mod 16 in both the in-bank and spill cases.
    function automatic logic entry_blocks(
        input logic [4:0]  vs,
        input logic        off,
        input logic [2:0]  ridx,
        input logic        live,
        input logic [4:0]  vd,
        input logic [2:0]  eidx,
        input logic [15:0] mask
    );
        logic [3:0] g;
        logic [3:0] start;
        logic [3:0] pos;
        logic [1:0] next_bank;
        logic       covered;
        g         = {vs[2:0], off};
        start     = {vd[2:0], 1'b0};
        pos       = g - start;
        next_bank = vd[4:3] + 2'd1;
        covered   = ((vs[4:3] == vd[4:3]) && (g >= start)) ||
                    ((vs[4:3] == next_bank) && (g < start));
        return live && (eidx != ridx) && !older(ridx, eidx) && covered && !mask[pos];
    endfunction

    // Table bookkeeping
    always_comb begin
        w_alloc_ready = ~&r_valid;
        w_free_idx    = '0;
        w_dup         = 1'b0;
        w_retire_hit  = '0;
        w_write_hit   = '0;
        w_count       = '0;
        for (int i = NR_RECORDS - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free_idx = EW'(i);
        end
        for (int i = 0; i < NR_RECORDS; i++) begin
            if (r_valid[i] && (r_idx[i] == alloc_instIndex)) w_dup = 1'b1;
            w_retire_hit[i] = retire_valid && r_valid[i] && (r_idx[i] == retire_instIndex);
            w_write_hit[i]  = write_valid && r_valid[i] && (r_idx[i] == write_instIndex);
            w_count         = w_count + 4'(r_valid[i]);
        end
        w_alloc_fire = alloc_valid && w_alloc_ready;
    end

    // Hazard check per reader against every entry
    always_comb begin
        w_elig = '0;
        for (int rd = 0; rd < NR_READERS; rd++) begin
            w_elig[rd] = read_valid[rd];
            for (int e = 0; e < NR_RECORDS; e++) begin
                if (entry_blocks(read_vs[5*rd +: 5], read_offset[rd],
                                 read_instIndex[3*rd +: 3],
                                 r_valid[e] && r_vd_valid[e],
                                 r_vd[e], r_idx[e], r_mask[e]))
                    w_elig[rd] = 1'b0;
            end
        end
    end

    // Round-robin pick: first eligible reader at or after r_rr_ptr
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_grant  = '0;
        for (int k = 0; k < NR_READERS; k++) begin
            if (!w_found && w_elig[(int'(r_rr_ptr) + k) % NR_READERS]) begin
                w_found  = 1'b1;
                w_winner = PW'((int'(r_rr_ptr) + k) % NR_READERS);
            end
        end
        if (w_found) w_grant[w_winner] = 1'b1;
        w_rr_next = (w_winner == PW'(NR_READERS - 1)) ? '0 : w_winner + PW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid    <= '0;
            r_vd_valid <= '0;
            r_rr_ptr   <= '0;
            r_error    <= 1'b0;
            for (int i = 0; i < NR_RECORDS; i++) begin
                r_vd[i]   <= '0;
                r_idx[i]  <= '0;
                r_mask[i] <= '0;
            end
        end else begin
            // Retire takes priority over a same-cycle write to the entry.
            for (int i = 0; i < NR_RECORDS; i++) begin
                if (w_retire_hit[i])
                    r_valid[i] <= 1'b0;
                else if (w_write_hit[i])
                    r_mask[i] <= r_mask[i] | write_elementMask;
            end
            // The free slot is never the target of a retire or write hit.
            if (w_alloc_fire && !w_dup) begin
                r_valid[w_free_idx]    <= 1'b1;
                r_vd_valid[w_free_idx] <= alloc_vd_valid;
                r_vd[w_free_idx]       <= alloc_vd;
                r_idx[w_free_idx]      <= alloc_instIndex;
                r_mask[w_free_idx]     <= '0;
            end
            if ((w_alloc_fire && w_dup) || (retire_valid && (w_retire_hit == '0)))
                r_error <= 1'b1;
            if (w_found)
                r_rr_ptr <= w_rr_next;
        end
    end

    assign alloc_ready  = w_alloc_ready;
    assign read_ready   = w_grant;
    assign record_count = w_count;
    assign error        = r_error;

endmodule

// File: tb/tb_chaining_record_table.sv
// ---------------------------------------------------------------------------
// tb_chaining_record_table
//
// Directed bench for chaining_record_table (NR_RECORDS=4, NR_READERS=2).
// Inputs change just after the falling edge; combinational outputs are
// sampled 1 time unit later, state updates land on the rising edge between.
// ---------------------------------------------------------------------------
module tb_chaining_record_table;

    logic        clock;
    logic        reset;
    logic        alloc_valid;
    logic        alloc_ready;
    logic        alloc_vd_valid;
    logic [4:0]  alloc_vd;
    logic [2:0]  alloc_instIndex;
    logic        write_valid;
    logic [2:0]  write_instIndex;
    logic [15:0] write_elementMask;
    logic        retire_valid;
    logic [2:0]  retire_instIndex;
    logic [1:0]  read_valid;
    logic [9:0]  read_vs;
    logic [1:0]  read_offset;
    logic [5:0]  read_instIndex;
    logic [1:0]  read_ready;
    logic [3:0]  record_count;
    logic        error;

    int checks = 0;
    int errors = 0;

    chaining_record_table #(.NR_RECORDS(4), .NR_READERS(2)) dut (
        .clock             (clock),
        .reset             (reset),
        .alloc_valid       (alloc_valid),
        .alloc_ready       (alloc_ready),
        .alloc_vd_valid    (alloc_vd_valid),
        .alloc_vd          (alloc_vd),
        .alloc_instIndex   (alloc_instIndex),
        .write_valid       (write_valid),
        .write_instIndex   (write_instIndex),
        .write_elementMask (write_elementMask),
        .retire_valid      (retire_valid),
        .retire_instIndex  (retire_instIndex),
        .read_valid        (read_valid),
        .read_vs           (read_vs),
        .read_offset       (read_offset),
        .read_instIndex    (read_instIndex),
        .read_ready        (read_ready),
        .record_count      (record_count),
        .error             (error)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_reader(input int n, input logic [4:0] vs, input logic off,
                              input logic [2:0] idx);
        read_vs[5*n +: 5]        = vs;
        read_offset[n]           = off;
        read_instIndex[3*n +: 3] = idx;
    endtask

    task automatic do_alloc(input logic [2:0] idx, input logic [4:0] vd, input logic vdv);
        alloc_valid     = 1'b1;
        alloc_instIndex = idx;
        alloc_vd        = vd;
        alloc_vd_valid  = vdv;
        step();
        alloc_valid     = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] idx, input logic [15:0] m);
        write_valid       = 1'b1;
        write_instIndex   = idx;
        write_elementMask = m;
        step();
        write_valid       = 1'b0;
    endtask

    task automatic do_retire(input logic [2:0] idx);
        retire_valid     = 1'b1;
        retire_instIndex = idx;
        step();
        retire_valid     = 1'b0;
    endtask

    initial begin
        reset             = 1'b0;
        alloc_valid       = 1'b0;
        alloc_vd_valid    = 1'b0;
        alloc_vd          = '0;
        alloc_instIndex   = '0;
        write_valid       = 1'b0;
        write_instIndex   = '0;
        write_elementMask = '0;
        retire_valid      = 1'b0;
        retire_instIndex  = '0;
        read_valid        = '0;
        read_vs           = '0;
        read_offset       = '0;
        read_instIndex    = '0;

        // Reset state
        settle();
        chk("rst_count", 32'(record_count), 32'd0);
        chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("rst_read_ready", 32'(read_ready), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // Basic chaining: vd=8 inst=1, reader0 vs=8 off=0 inst=2
        do_alloc(3'd1, 5'd8, 1'b1);
        set_reader(0, 5'd8, 1'b0, 3'd2);
        read_valid = 2'b01;
        settle();
        chk("t1_count", 32'(record_count), 32'd1);
        chk("t1_blocked", 32'(read_ready), 32'b00);
        write_valid       = 1'b1;
        write_instIndex   = 3'd1;
        write_elementMask = 16'h0001;
        settle();
        chk("t1_write_cycle", 32'(read_ready), 32'b00);
        step();
        write_valid = 1'b0;
        settle();
        chk("t1_granted", 32'(read_ready), 32'b01);
        read_valid = 2'b00;
        do_retire(3'd1);
        settle();
        chk("t1_retired_count", 32'(record_count), 32'd0);

        // Wrap coverage: vd=14 (start 12), reader vs=16 -> position 4/5
        do_alloc(3'd1, 5'd14, 1'b1);
        set_reader(0, 5'd16, 1'b0, 3'd2);
        read_valid = 2'b01;
        settle();
        chk("t2_wrap_blocked", 32'(read_ready), 32'b00);
        do_write(3'd1, 16'h0010);
        settle();
        chk("t2_wrap_granted", 32'(read_ready), 32'b01);
        set_reader(0, 5'd16, 1'b1, 3'd2);
        settle();
        chk("t2_wrap_pos5_blocked", 32'(read_ready), 32'b00);
        set_reader(0, 5'd8, 1'b0, 3'd2);
        settle();
        chk("t2_below_start", 32'(read_ready), 32'b01);
        read_valid = 2'b00;
        do_retire(3'd1);

        // Ordering
        do_alloc(3'd1, 5'd8, 1'b1);
        set_reader(0, 5'd8, 1'b0, 3'd0);
        read_valid = 2'b01;
        settle();
        chk("t3_reader_older", 32'(read_ready), 32'b01);
        read_valid = 2'b00;
        do_retire(3'd1);
        do_alloc(3'd3, 5'd8, 1'b1);
        set_reader(0, 5'd8, 1'b0, 3'd4);
        read_valid = 2'b01;
        settle();
        chk("t3_reader_younger", 32'(read_ready), 32'b00);
        set_reader(0, 5'd8, 1'b0, 3'd3);
        settle();
        chk("t3_same_index", 32'(read_ready), 32'b01);
        read_valid = 2'b00;
        do_retire(3'd3);

        // Record without vector destination never blocks
        do_alloc(3'd2, 5'd8, 1'b0);
        set_reader(0, 5'd8, 1'b0, 3'd5);
        read_valid = 2'b01;
        settle();
        chk("t3_no_vd", 32'(read_ready), 32'b01);
        read_valid = 2'b00;
        do_retire(3'd2);

        // Arbitration: park the pointer on reader0, then alternate
        set_reader(0, 5'd0, 1'b0, 3'd0);
        set_reader(1, 5'd1, 1'b0, 3'd0);
        read_valid = 2'b10;
        settle();
        chk("t4_only_r1", 32'(read_ready), 32'b10);
        step();
        read_valid = 2'b11;
        settle();
        chk("t4_rr_0", 32'(read_ready), 32'b01);
        step();
        settle();
        chk("t4_rr_1", 32'(read_ready), 32'b10);
        step();
        settle();
        chk("t4_rr_2", 32'(read_ready), 32'b01);
        step();
        settle();
        chk("t4_rr_3", 32'(read_ready), 32'b10);
        read_valid = 2'b00;
        step();

        // Reader1 blocked by vd=8 inst=1, reader0 reads bank 0 freely
        do_alloc(3'd1, 5'd8, 1'b1);
        set_reader(0, 5'd0, 1'b0, 3'd2);
        set_reader(1, 5'd8, 1'b0, 3'd2);
        read_valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("t4_r1_blocked", 32'(read_ready), 32'b01);
            step();
        end
        read_valid = 2'b00;
        do_retire(3'd1);

        // Full table, retire + alloc in the same cycle
        do_alloc(3'd0, 5'd0, 1'b0);
        do_alloc(3'd1, 5'd0, 1'b0);
        do_alloc(3'd2, 5'd0, 1'b0);
        do_alloc(3'd3, 5'd0, 1'b0);
        settle();
        chk("t5_full_count", 32'(record_count), 32'd4);
        chk("t5_full_not_ready", 32'(alloc_ready), 32'd0);
        retire_valid     = 1'b1;
        retire_instIndex = 3'd2;
        alloc_valid      = 1'b1;
        alloc_instIndex  = 3'd4;
        alloc_vd         = 5'd0;
        alloc_vd_valid   = 1'b0;
        settle();
        chk("t5_retire_alloc_ready", 32'(alloc_ready), 32'd0);
        step();
        retire_valid = 1'b0;
        alloc_valid  = 1'b0;
        settle();
        chk("t5_after_retire_count", 32'(record_count), 32'd3);
        chk("t5_after_retire_ready", 32'(alloc_ready), 32'd1);
        chk("t5_full_no_error", 32'(error), 32'd0);
        do_alloc(3'd4, 5'd0, 1'b0);
        settle();
        chk("t5_refill_count", 32'(record_count), 32'd4);
        chk("t5_entry2_valid", 32'(dut.r_valid[2]), 32'd1);
        chk("t5_entry2_index", 32'(dut.r_idx[2]), 32'd4);

        // Duplicate allocation sets sticky error
        do_retire(3'd3);
        do_alloc(3'd0, 5'd0, 1'b0);
        settle();
        chk("t6_dup_error", 32'(error), 32'd1);
        chk("t6_dup_count", 32'(record_count), 32'd3);
        step();
        step();
        settle();
        chk("t6_error_sticky", 32'(error), 32'd1);

        // Asynchronous reset mid-cycle clears everything
        #2;
        reset = 1'b0;
        read_valid = 2'b11;
        settle();
        chk("t6_reset_error", 32'(error), 32'd0);
        chk("t6_reset_count", 32'(record_count), 32'd0);
        chk("t6_reset_read", 32'(read_ready), 32'b01);
        step();
        reset = 1'b1;
        read_valid = 2'b00;
        settle();
        chk("t6_reset_alloc_ready", 32'(alloc_ready), 32'd1);

        // Retire of an absent index sets error
        do_retire(3'd7);
        settle();
        chk("t6_absent_retire", 32'(error), 32'd1);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
